// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch unit: credit-limited prefetch into an in-order instruction buffer
// Optional stall counter port fetch_stall_cnt exists only when FETCH_PERF_COUNT_EN is defined.
module fetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        out_ready
`ifdef FETCH_PERF_COUNT_EN
  ,
  output logic [31:0] fetch_stall_cnt
`endif
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic [CW-1:0] count;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [31:0]   buf_instr [DEPTH];
  logic [31:0]   buf_pc    [DEPTH];

  logic          req_fire;
  logic          keep_resp;
  logic          pop;
  logic [CW:0]   in_use;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Credits count both in-flight requests and buffered words, so every response has a slot.
  always_comb begin
    in_use         = {1'b0, outstanding} + {1'b0, count};
    imem_req_valid = !reset && !redirect_valid && (in_use < (CW + 1)'(DEPTH));
    imem_req_addr  = fetch_pc;
    req_fire       = imem_req_valid && imem_req_ready;
    keep_resp      = imem_resp_valid && !redirect_valid && (discard == '0);
    out_valid      = !reset && !redirect_valid && (count != '0);
    out_instr      = (!reset && count != '0) ? buf_instr[rd_ptr] : '0;
    out_pc         = (!reset && count != '0) ? buf_pc[rd_ptr] : '0;
    pop            = out_valid && out_ready;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc    <= RESET_PC & ~32'h3;
      resp_pc     <= RESET_PC & ~32'h3;
      outstanding <= '0;
      discard     <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      if (req_fire && !imem_resp_valid) begin
        outstanding <= outstanding + 1'b1;
      end else if (!req_fire && imem_resp_valid) begin
        outstanding <= outstanding - 1'b1;
      end

      if (redirect_valid) begin
        // Everything still in flight after this cycle belongs to the old path.
        fetch_pc <= redirect_pc & ~32'h3;
        resp_pc  <= redirect_pc & ~32'h3;
        discard  <= outstanding - CW'(imem_resp_valid);
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (req_fire) begin
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (imem_resp_valid && discard != '0) begin
          discard <= discard - 1'b1;
        end
        if (keep_resp) begin
          resp_pc <= resp_pc + 32'd4;
          wr_ptr  <= bump(wr_ptr);
        end
        if (pop) begin
          rd_ptr <= bump(rd_ptr);
        end
        if (keep_resp && !pop) begin
          count <= count + 1'b1;
        end else if (!keep_resp && pop) begin
          count <= count - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (keep_resp) begin
      buf_instr[wr_ptr] <= imem_resp_data;
      buf_pc[wr_ptr]    <= resp_pc;
    end
  end

`ifdef FETCH_PERF_COUNT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_stall_cnt <= '0;
    end else if (!out_valid) begin
      fetch_stall_cnt <= fetch_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit with in-order memory and stream model
module tb_fetch_unit;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready = 1'b0;
`ifdef FETCH_PERF_COUNT_EN
  logic [31:0] fetch_stall_cnt;
  int          stall_model;
`endif

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clock(clock),
    .reset(reset),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid),
    .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data),
    .out_valid(out_valid),
    .out_instr(out_instr),
    .out_pc(out_pc),
    .out_ready(out_ready)
`ifdef FETCH_PERF_COUNT_EN
    ,
    .fetch_stall_cnt(fetch_stall_cnt)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } mem_req_t;

  typedef struct {
    bit          redirect;
    logic [31:0] rpc;
    bit          rdy_out;
    bit          exp_rv;
    logic [31:0] exp_addr;
    bit          exp_ov;
    logic [31:0] exp_pc;
  } vec_t;

  mem_req_t    memq[$];
  logic [31:0] fq[$];
  logic [31:0] exp_fetch;
  int          cyc;
  int          checks;
  int          errors;
  int          lat;

  bit          drv_reset;
  bit          drv_redirect;
  logic [31:0] drv_rpc;
  bit          drv_req_ready;
  bit          drv_out_ready;

  bit          obs_req_valid;
  logic [31:0] obs_req_addr;
  bit          obs_out_valid;
  logic [31:0] obs_out_pc;
  bit          obs_fire;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic check1(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %b want %b (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // One clock cycle: drive inputs, check against the stream model, then advance the model.
  task automatic step();
    mem_req_t r;
    mem_req_t nr;
    bit       exp_rv;
    bit       exp_ov;
    bit       fire;
    int       d;
    @(negedge clock);
    reset          = drv_reset;
    redirect_valid = drv_redirect && !drv_reset;
    redirect_pc    = drv_rpc;
    imem_req_ready = drv_req_ready;
    out_ready      = drv_out_ready;
    if (!drv_reset && memq.size() > 0 && memq[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(memq[0].addr);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
    end
    #2;
    obs_req_valid = imem_req_valid;
    obs_req_addr  = imem_req_addr;
    obs_out_valid = out_valid;
    obs_out_pc    = out_pc;
    obs_fire      = imem_req_valid && imem_req_ready;
    if (reset) begin
      check1("rst_req_valid", imem_req_valid, 1'b0);
      check1("rst_out_valid", out_valid, 1'b0);
      check32("rst_out_instr", out_instr, 32'h0);
      check32("rst_out_pc", out_pc, 32'h0);
      memq.delete();
      fq.delete();
      exp_fetch = RESET_PC;
`ifdef FETCH_PERF_COUNT_EN
      stall_model = 0;
`endif
    end else begin
      exp_rv = !redirect_valid && (memq.size() + fq.size() < DEPTH);
      exp_ov = !redirect_valid && (fq.size() > 0);
      check1("req_valid", imem_req_valid, exp_rv);
      if (exp_rv) check32("req_addr", imem_req_addr, exp_fetch);
      check1("out_valid", out_valid, exp_ov);
      if (exp_ov) begin
        check32("out_pc", out_pc, fq[0]);
        check32("out_instr", out_instr, mem_word(fq[0]));
      end
`ifdef FETCH_PERF_COUNT_EN
      check32("stall_cnt", fetch_stall_cnt, 32'(stall_model));
      if (!exp_ov) stall_model++;
`endif
      fire = exp_rv && drv_req_ready;
      if (exp_ov && drv_out_ready) void'(fq.pop_front());
      if (imem_resp_valid) begin
        r = memq.pop_front();
        if (!redirect_valid && !r.stale) fq.push_back(r.addr);
      end
      if (redirect_valid) begin
        foreach (memq[i]) memq[i].stale = 1'b1;
        fq.delete();
        exp_fetch = redirect_pc & ~32'h3;
      end
      if (fire) begin
        d = cyc + lat;
        if (memq.size() > 0 && d <= memq[memq.size() - 1].due) d = memq[memq.size() - 1].due + 1;
        nr.addr  = exp_fetch;
        nr.due   = d;
        nr.stale = 1'b0;
        memq.push_back(nr);
        exp_fetch = exp_fetch + 32'd4;
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    drv_reset    = 1'b1;
    drv_redirect = 1'b0;
    step();
    step();
    drv_reset = 1'b0;
  endtask

  initial begin
    vec_t tbl[15];
    int   fires;
    bit   seen;
    checks        = 0;
    errors        = 0;
    cyc           = 0;
    lat           = 1;
    drv_rpc       = '0;
    drv_req_ready = 1'b1;
    drv_out_ready = 1'b1;

    tbl[0]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h0,   1'b0, 32'h0};
    tbl[1]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h4,   1'b0, 32'h0};
    tbl[2]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h8,   1'b1, 32'h0};
    tbl[3]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'hC,   1'b1, 32'h4};
    tbl[4]  = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h10,  1'b1, 32'h8};
    tbl[5]  = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h14,  1'b1, 32'h8};
    tbl[6]  = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b1, 32'h8};
    tbl[7]  = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b1, 32'h8};
    tbl[8]  = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b1, 32'h8};
    tbl[9]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h18,  1'b1, 32'hC};
    tbl[10] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h1C,  1'b1, 32'h10};
    tbl[11] = '{1'b1, 32'h103, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0};
    tbl[12] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h100, 1'b0, 32'h0};
    tbl[13] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h104, 1'b0, 32'h0};
    tbl[14] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h108, 1'b1, 32'h100};

    // Directed per-cycle table, 1-cycle memory
    do_reset();
    foreach (tbl[i]) begin
      drv_redirect  = tbl[i].redirect;
      drv_rpc       = tbl[i].rpc;
      drv_out_ready = tbl[i].rdy_out;
      step();
      check1("tbl_req_valid", obs_req_valid, tbl[i].exp_rv);
      if (tbl[i].exp_rv) check32("tbl_req_addr", obs_req_addr, tbl[i].exp_addr);
      check1("tbl_out_valid", obs_out_valid, tbl[i].exp_ov);
      if (tbl[i].exp_ov) check32("tbl_out_pc", obs_out_pc, tbl[i].exp_pc);
    end
    drv_redirect = 1'b0;

    // Consumer stalled: exactly DEPTH requests, then resume at 0x10
    do_reset();
    drv_out_ready = 1'b0;
    fires = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (obs_fire) fires++;
    end
    check32("stall_fire_count", 32'(fires), 32'd4);
    check1("stall_req_valid", obs_req_valid, 1'b0);
    drv_out_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      seen = obs_fire;
    end
    check1("resume_timeout", seen, 1'b1);
    check32("resume_addr", obs_req_addr, 32'h10);
    for (int i = 0; i < 8; i++) step();

    // 3-cycle memory, redirect with 2 requests in flight
    lat = 3;
    do_reset();
    step();
    step();
    drv_redirect = 1'b1;
    drv_rpc      = 32'h100;
    step();
    check1("redir_req_valid", obs_req_valid, 1'b0);
    drv_redirect = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      seen = obs_out_valid;
    end
    check1("redir_timeout", seen, 1'b1);
    check32("redir_first_pc", obs_out_pc, 32'h100);
    for (int i = 0; i < 6; i++) step();

    // Memory not ready for 5 cycles
    lat = 1;
    do_reset();
    drv_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check1("hold_valid", obs_req_valid, 1'b1);
      check32("hold_addr", obs_req_addr, RESET_PC);
    end
    drv_req_ready = 1'b1;
    step();
    check1("hold_fire", obs_fire, 1'b1);
    check32("hold_fire_addr", obs_req_addr, RESET_PC);
    step();
    check32("hold_next_addr", obs_req_addr, RESET_PC + 32'd4);

    // Address wrap at the top of the space
    drv_redirect = 1'b1;
    drv_rpc      = 32'hFFFF_FFFE;
    step();
    drv_redirect = 1'b0;
    step();
    check32("wrap_addr0", obs_req_addr, 32'hFFFF_FFFC);
    step();
    check32("wrap_addr1", obs_req_addr, 32'h0000_0000);
    for (int i = 0; i < 6; i++) step();

    // Randomized traffic with sporadic redirects
    do_reset();
    for (int i = 0; i < 400; i++) begin
      lat           = int'($urandom_range(1, 3));
      drv_req_ready = ($urandom_range(0, 3) != 0);
      drv_out_ready = ($urandom_range(0, 2) != 0);
      drv_redirect  = ($urandom_range(0, 15) == 0);
      drv_rpc       = $urandom;
      step();
    end

    // Redirect every 4th cycle
    do_reset();
    for (int i = 0; i < 200; i++) begin
      lat           = int'($urandom_range(1, 3));
      drv_req_ready = ($urandom_range(0, 3) != 0);
      drv_out_ready = ($urandom_range(0, 1) != 0);
      drv_redirect  = (i % 4 == 3);
      drv_rpc       = $urandom;
      step();
    end
    drv_redirect = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
